// File: rtl/clock_switchover_multi.sv
// clock_switchover_multi: qualifies N candidate clocks by toggle activity and picks the highest alive one.
// Every switch is wrapped in a downstream reset, with the select change delayed inside it.
module clock_switchover_multi #(
    parameter int CHANNEL_COUNT   = 2,
    parameter int WINDOW_CYCLES   = 64,
    parameter int MIN_EDGES       = 4,
    parameter int STABLE_WINDOWS  = 4,
    parameter int RESET_CYCLES    = 10,
    parameter int SELECT_DELAY    = 3,
    parameter int FAILOVER_ENABLE = 1,
    localparam int SELECT_WIDTH   = (CHANNEL_COUNT > 2) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNEL_COUNT-1:0] clock_toggle,
    output logic [SELECT_WIDTH-1:0]  clock_select,
    output logic                     downstream_reset,
    output logic [CHANNEL_COUNT-1:0] channel_alive,
    output logic                     no_clock_alive,
    output logic                     switch_pulse
);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam int SW = $clog2(STABLE_WINDOWS + 1);
    localparam int CW = $clog2(RESET_CYCLES);
    localparam logic [WW-1:0] W_LAST    = WW'(WINDOW_CYCLES - 1);
    localparam logic [EW:0]   E_MIN     = (EW+1)'(MIN_EDGES);
    localparam logic [EW-1:0] E_MAX     = EW'(MIN_EDGES);
    localparam logic [SW-1:0] S_MAX     = SW'(STABLE_WINDOWS);
    localparam logic [CW-1:0] PRE_LAST  = CW'(SELECT_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);

    if (SELECT_DELAY < 1 || RESET_CYCLES <= SELECT_DELAY || MIN_EDGES < 1 ||
        WINDOW_CYCLES < 2 * MIN_EDGES || STABLE_WINDOWS < 1 || CHANNEL_COUNT < 2) begin : g_param_check
        $error("clock_switchover_multi: invalid parameter combination");
    end

    typedef enum logic [1:0] {RUN, PRE, HOLD} state_t;

    logic [CHANNEL_COUNT-1:0] sync1, sync2, hist, edges, alive_nxt;
    logic [WW-1:0]            wcnt;
    logic                     eow;
    logic [EW-1:0]            edge_cnt   [CHANNEL_COUNT];
    logic [EW:0]              total      [CHANNEL_COUNT];
    logic [SW-1:0]            stable_cnt [CHANNEL_COUNT];
    logic [SW-1:0]            stable_nxt [CHANNEL_COUNT];

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [SELECT_WIDTH-1:0]  pending, pending_nxt, select_nxt, target;
    logic                     dreset_nxt, pulse_nxt, switching, switching_nxt, failed;

    assign edges = sync2 ^ hist;
    assign eow   = wcnt == W_LAST;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= clock_toggle;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // The end-of-window cycle's own edge is folded into total before the decision.
    always_comb begin
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            total[i]      = {1'b0, edge_cnt[i]} + {{EW{1'b0}}, edges[i]};
            stable_nxt[i] = (total[i] >= E_MIN) ?
                            ((stable_cnt[i] == S_MAX) ? S_MAX : stable_cnt[i] + 1'b1) : '0;
            alive_nxt[i]  = stable_nxt[i] == S_MAX;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt           <= '0;
            channel_alive  <= '0;
            no_clock_alive <= 1'b1;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                edge_cnt[i]   <= '0;
                stable_cnt[i] <= '0;
            end
        end else begin
            wcnt <= eow ? '0 : wcnt + 1'b1;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                edge_cnt[i] <= eow ? '0 : ((total[i] >= E_MIN) ? E_MAX : total[i][EW-1:0]);
                if (eow)
                    stable_cnt[i] <= stable_nxt[i];
            end
            if (eow) begin
                channel_alive  <= alive_nxt;
                no_clock_alive <= alive_nxt == '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= HOLD;
            cnt              <= '0;
            pending          <= '0;
            clock_select     <= '0;
            downstream_reset <= 1'b1;
            switch_pulse     <= 1'b0;
            switching        <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            pending          <= pending_nxt;
            clock_select     <= select_nxt;
            downstream_reset <= dreset_nxt;
            switch_pulse     <= pulse_nxt;
            switching        <= switching_nxt;
        end
    end

    // switching distinguishes a real switch from the startup hold, which must not pulse.
    always_comb begin
        target = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++)
            if (channel_alive[i])
                target = SELECT_WIDTH'(i);
        failed        = (FAILOVER_ENABLE != 0) && !channel_alive[clock_select];
        state_nxt     = state;
        cnt_nxt       = cnt + 1'b1;
        pending_nxt   = pending;
        select_nxt    = clock_select;
        dreset_nxt    = downstream_reset;
        pulse_nxt     = 1'b0;
        switching_nxt = switching;
        case (state)
            RUN: begin
                cnt_nxt = '0;
                if (!no_clock_alive && (target > clock_select || failed)) begin
                    state_nxt     = PRE;
                    pending_nxt   = target;
                    dreset_nxt    = 1'b1;
                    switching_nxt = 1'b1;
                end
            end
            PRE: begin
                if (cnt == PRE_LAST) begin
                    select_nxt = pending;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    dreset_nxt    = 1'b0;
                    pulse_nxt     = switching;
                    switching_nxt = 1'b0;
                    state_nxt     = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_clock_switchover_multi.sv
// tb_clock_switchover_multi: directed checks of qualification, upgrade, failover and reset behaviour.
module tb_clock_switchover_multi;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] clock_toggle = '0;
    logic       sel, dr, noclk, pulse;
    logic [1:0] alive;
    logic       sel_b, dr_b, noclk_b, pulse_b;
    logic [1:0] alive_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int per [2];
    int ph [2];
    int sched = 0;

    clock_switchover_multi dut (
        .clock(clock), .reset(reset), .clock_toggle(clock_toggle),
        .clock_select(sel), .downstream_reset(dr), .channel_alive(alive),
        .no_clock_alive(noclk), .switch_pulse(pulse)
    );

    clock_switchover_multi #(.FAILOVER_ENABLE(0)) dut_nofo (
        .clock(clock), .reset(reset), .clock_toggle(clock_toggle),
        .clock_select(sel_b), .downstream_reset(dr_b), .channel_alive(alive_b),
        .no_clock_alive(noclk_b), .switch_pulse(pulse_b)
    );

    always #5 clock = ~clock;

    // One monitor-clock step; toggles change 1 time unit after the edge.
    task automatic tick();
        int m;
        @(posedge clock);
        #1;
        cyc++;
        m = cyc % 64;
        for (int c = 0; c < 2; c++) begin
            if (per[c] != 0) begin
                ph[c]++;
                if (ph[c] >= per[c]) begin
                    ph[c] = 0;
                    clock_toggle[c] = ~clock_toggle[c];
                end
            end
        end
        if ((sched == 3 && (m == 10 || m == 20 || m == 61)) ||
            (sched == 4 && (m == 10 || m == 20 || m == 30 || m == 61)))
            clock_toggle[1] = ~clock_toggle[1];
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clock_toggle = '0;
        sched = 0;
        for (int c = 0; c < 2; c++) begin
            per[c] = 0;
            ph[c] = 0;
        end
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic saw;
        do_reset();
        checks++; if (dr !== 1'b1 || sel !== 1'b0 || alive !== 2'b00 || noclk !== 1'b1 || pulse !== 1'b0) begin
            failures++; $display("FAIL reset_values got dr=%b sel=%b alive=%b noclk=%b pulse=%b exp 1 0 00 1 0", dr, sel, alive, noclk, pulse); end
        run_to(9);
        checks++; if (dr !== 1'b1) begin failures++; $display("FAIL startup_dr_c9 got %b exp 1", dr); end
        tick();
        checks++; if (dr !== 1'b0) begin failures++; $display("FAIL startup_dr_c10 got %b exp 0", dr); end
        saw = 1'b0;
        while (cyc < 300) begin
            tick();
            saw = saw | pulse | dr;
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL idle_no_switch got %b exp 0", saw); end
        checks++; if (sel !== 1'b0 || alive !== 2'b00 || noclk !== 1'b1) begin
            failures++; $display("FAIL idle_state got sel=%b alive=%b noclk=%b exp 0 00 1", sel, alive, noclk); end
    endtask

    task automatic test_qualify_ch0();
        logic saw;
        do_reset();
        per[0] = 2;
        run_to(255);
        checks++; if (alive !== 2'b00) begin failures++; $display("FAIL ch0_alive_c255 got %b exp 00", alive); end
        tick();
        checks++; if (alive !== 2'b01 || noclk !== 1'b0) begin
            failures++; $display("FAIL ch0_alive_c256 got alive=%b noclk=%b exp 01 0", alive, noclk); end
        saw = 1'b0;
        while (cyc < 280) begin
            tick();
            saw = saw | pulse | dr;
        end
        checks++; if (saw !== 1'b0 || sel !== 1'b0) begin
            failures++; $display("FAIL ch0_no_switch got saw=%b sel=%b exp 0 0", saw, sel); end
    endtask

    task automatic test_upgrade();
        do_reset();
        per[0] = 2;
        per[1] = 3;
        run_to(256);
        checks++; if (alive !== 2'b11 || dr !== 1'b0) begin
            failures++; $display("FAIL up_alive_c256 got alive=%b dr=%b exp 11 0", alive, dr); end
        tick();
        checks++; if (dr !== 1'b1 || sel !== 1'b0) begin
            failures++; $display("FAIL up_dr_rise_c257 got dr=%b sel=%b exp 1 0", dr, sel); end
        run_to(259);
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL up_sel_c259 got %b exp 0", sel); end
        tick();
        checks++; if (sel !== 1'b1 || sel_b !== 1'b1) begin
            failures++; $display("FAIL up_sel_c260 got sel=%b sel_b=%b exp 1 1", sel, sel_b); end
        run_to(266);
        checks++; if (dr !== 1'b1 || pulse !== 1'b0) begin
            failures++; $display("FAIL up_hold_c266 got dr=%b pulse=%b exp 1 0", dr, pulse); end
        tick();
        checks++; if (dr !== 1'b0 || pulse !== 1'b1 || pulse_b !== 1'b1) begin
            failures++; $display("FAIL up_done_c267 got dr=%b pulse=%b pulse_b=%b exp 0 1 1", dr, pulse, pulse_b); end
        tick();
        checks++; if (pulse !== 1'b0) begin failures++; $display("FAIL up_pulse_c268 got %b exp 0", pulse); end
    endtask

    task automatic test_failover();
        per[1] = 0;
        run_to(383);
        checks++; if (alive !== 2'b11 || dr !== 1'b0) begin
            failures++; $display("FAIL fo_alive_c383 got alive=%b dr=%b exp 11 0", alive, dr); end
        tick();
        checks++; if (alive !== 2'b01 || alive_b !== 2'b01) begin
            failures++; $display("FAIL fo_alive_c384 got alive=%b alive_b=%b exp 01 01", alive, alive_b); end
        tick();
        checks++; if (dr !== 1'b1 || dr_b !== 1'b0) begin
            failures++; $display("FAIL fo_dr_c385 got dr=%b dr_b=%b exp 1 0", dr, dr_b); end
        run_to(387);
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL fo_sel_c387 got %b exp 1", sel); end
        tick();
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL fo_sel_c388 got %b exp 0", sel); end
        run_to(394);
        checks++; if (dr !== 1'b1) begin failures++; $display("FAIL fo_dr_c394 got %b exp 1", dr); end
        tick();
        checks++; if (dr !== 1'b0 || pulse !== 1'b1) begin
            failures++; $display("FAIL fo_done_c395 got dr=%b pulse=%b exp 0 1", dr, pulse); end
        checks++; if (sel_b !== 1'b1 || dr_b !== 1'b0 || pulse_b !== 1'b0) begin
            failures++; $display("FAIL nofo_hold got sel=%b dr=%b pulse=%b exp 1 0 0", sel_b, dr_b, pulse_b); end
    endtask

    task automatic test_edge_threshold();
        do_reset();
        sched = 3;
        run_to(320);
        checks++; if (alive !== 2'b00 || noclk !== 1'b1) begin
            failures++; $display("FAIL three_edges got alive=%b noclk=%b exp 00 1", alive, noclk); end
        do_reset();
        sched = 4;
        run_to(255);
        checks++; if (alive !== 2'b00) begin failures++; $display("FAIL four_edges_c255 got %b exp 00", alive); end
        tick();
        checks++; if (alive !== 2'b10 || noclk !== 1'b0) begin
            failures++; $display("FAIL four_edges_c256 got alive=%b noclk=%b exp 10 0", alive, noclk); end
    endtask

    task automatic test_reset_mid_switch();
        do_reset();
        per[0] = 2;
        per[1] = 3;
        run_to(262);
        checks++; if (dr !== 1'b1 || sel !== 1'b1) begin
            failures++; $display("FAIL mid_hold_c262 got dr=%b sel=%b exp 1 1", dr, sel); end
        reset = 1'b1;
        per[0] = 0;
        per[1] = 0;
        #1;
        checks++; if (sel !== 1'b0 || dr !== 1'b1 || alive !== 2'b00 || noclk !== 1'b1 || pulse !== 1'b0) begin
            failures++; $display("FAIL mid_reset got sel=%b dr=%b alive=%b noclk=%b pulse=%b exp 0 1 00 1 0", sel, dr, alive, noclk, pulse); end
        tick();
        reset = 1'b0;
        cyc = 0;
        run_to(9);
        checks++; if (dr !== 1'b1) begin failures++; $display("FAIL rerun_dr_c9 got %b exp 1", dr); end
        tick();
        checks++; if (dr !== 1'b0 || sel !== 1'b0 || pulse !== 1'b0) begin
            failures++; $display("FAIL rerun_c10 got dr=%b sel=%b pulse=%b exp 0 0 0", dr, sel, pulse); end
    endtask

    initial begin
        per[0] = 0;
        per[1] = 0;
        ph[0] = 0;
        ph[1] = 0;
        test_reset();
        test_qualify_ch0();
        test_upgrade();
        test_failover();
        test_edge_threshold();
        test_reset_mid_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_switchover_multi.md
Name: clock_switchover_multi

Overview:
- Multi-channel, repeatable successor to the one-shot clock switchover.
- Monitors N candidate clocks using divided-by-2 toggle signals, sampled on an always-running monitor clock.
- Qualifies each candidate as alive after a sustained period of activity, then selects the highest-priority alive candidate.
- Supports upgrade switchovers and failover to a lower channel when the selected clock dies.
- Drives a PLL/MMCM/BUFGMUX clock select and a downstream reset sequenced around every switch.

Parameters:
- CHANNEL_COUNT, 2, number of candidate clocks; channel 0 is the lowest priority, highest index is preferred.
- WINDOW_CYCLES, 64, length of one activity-measurement window, in monitor clock cycles.
- MIN_EDGES, 4, toggle edges per window needed for a channel to count as active in that window.
- STABLE_WINDOWS, 4, consecutive active windows needed before a channel is alive.
- RESET_CYCLES, 10, cycles downstream_reset stays high per switch.
- SELECT_DELAY, 3, cycles after downstream_reset rises before clock_select changes.
- FAILOVER_ENABLE, 1, 1: switch away from a dead selected clock; 0: upgrades only.
- Local SELECT_WIDTH = max(1, clog2(CHANNEL_COUNT)).

Ports:
- clock  input  1  always-running monitor clock; all logic runs on it.
- reset  input  1  asynchronous, active-high reset.
- clock_toggle  input  CHANNEL_COUNT  per-channel divide-by-2 toggle from each candidate domain; asynchronous.
- clock_select  output  SELECT_WIDTH  binary index of the selected candidate.
- downstream_reset  output  1  reset for the PLL and downstream logic.
- channel_alive  output  CHANNEL_COUNT  registered qualification status per channel.
- no_clock_alive  output  1  high when no channel is alive.
- switch_pulse  output  1  one-cycle pulse when a switch sequence completes.

Behaviour:
- Reset values (asynchronous, immediate):
  - clock_select=0, downstream_reset=1, channel_alive=0, no_clock_alive=1, switch_pulse=0.
  - All counters zero; FSM in HOLD with RESET_CYCLES remaining.
- Input synchronisation and edge detection:
  - Each clock_toggle bit passes through a 2-flop synchroniser plus one history flop.
  - edge[i] = sync XOR history.
  - Toggle rate must be below clock/2. Faster inputs alias, and correct behaviour is not required.
- Window counter: free-running, 0..WINDOW_CYCLES-1, wraps.
- Per-channel edge counter: saturates at MIN_EDGES.
- End-of-window cycle (window count = WINDOW_CYCLES-1):
  - active[i] = (edges including this cycle's edge) >= MIN_EDGES.
  - Edge counters restart at 0 next cycle.
- Per-channel stable counter, updated on end-of-window:
  - active: increment, saturating at STABLE_WINDOWS.
  - inactive: clear to 0.
- channel_alive[i] = (stable count == STABLE_WINDOWS), registered; it changes 1 cycle after end-of-window.
- no_clock_alive = (channel_alive == 0), registered alongside channel_alive.
- target = highest index with channel_alive set.
- FSM:
  - RUN:
    - Start a switch when any channel is alive and either:
      - target > clock_select (upgrade), or
      - FAILOVER_ENABLE=1 and channel_alive[clock_select]=0 (failover).
    - Starting a switch latches pending=target, sets downstream_reset=1, enters PRE.
    - If no channel is alive: hold clock_select, no switch.
    - No action when target == clock_select.
  - PRE: count SELECT_DELAY cycles, then clock_select <= pending and enter HOLD.
  - HOLD: count until downstream_reset has been high exactly RESET_CYCLES cycles, then downstream_reset <= 0, switch_pulse=1 for 1 cycle, enter RUN.
  - Startup is HOLD without a select change, so downstream_reset falls RESET_CYCLES cycles after reset release.
- Switch timing, for a decision in RUN at cycle T:
  - downstream_reset high from T+1 through T+RESET_CYCLES inclusive.
  - clock_select updates at T+1+SELECT_DELAY.
  - switch_pulse at T+1+RESET_CYCLES.
  - The next decision is possible at T+1+RESET_CYCLES.
- Aliveness changes during PRE/HOLD do not alter pending; they are re-evaluated in RUN. A switch to a channel that died mid-sequence therefore triggers an immediate failover.
- Elaboration error if any of these fail:
  - SELECT_DELAY >= 1
  - RESET_CYCLES > SELECT_DELAY
  - MIN_EDGES >= 1
  - WINDOW_CYCLES >= 2*MIN_EDGES
  - STABLE_WINDOWS >= 1
  - CHANNEL_COUNT >= 2
- Reset asserted mid-sequence: immediate return to reset values; qualification restarts from zero.

Test Plan:
1. Defaults, no toggles after reset release -> downstream_reset high exactly 10 cycles then low; clock_select=0; channel_alive=00; no_clock_alive=1; switch_pulse never fires.
2. Channel 0 toggles every 2 cycles -> channel_alive[0]=1 one cycle after the 4th end-of-window; no_clock_alive=0; no switch because select is already 0.
3. Channel 1 then toggles every 3 cycles -> after 4 windows alive[1]=1; next cycle downstream_reset rises; clock_select 0->1 three cycles later; reset falls after 10 high cycles; switch_pulse one cycle.
4. Channel 1 toggles stop -> at first window with <4 edges alive[1]=0; failover sequence to select 0 with identical timing. Rerun with FAILOVER_ENABLE=0 -> select stays 1, downstream_reset stays 0.
5. Channel 1 gives exactly 3 edges per window -> never alive. 4 edges per window -> alive after 4 windows. Edge on the final window cycle counts.
6. Reset asserted during HOLD of a 0->1 switch -> same cycle: clock_select=0, downstream_reset=1, channel_alive=0; startup sequence repeats after release.
